// File: rtl/reg_file.sv
// reg_file: 2**DEPTH_LOG2 x WIDTH general-purpose register file.
// Two operand read ports plus a debug read port, all combinational.
// One synchronous write port. r0 is hardwired to zero.
// An asynchronous active-high reset clears every register.
// With BYPASS=1, a write pending this cycle is forwarded to any read port
// that addresses the same register.
module reg_file #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] raddr_A,
  input  logic [DEPTH_LOG2-1:0] raddr_B,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  we,
  output logic [WIDTH-1:0]      rdata_A,
  output logic [WIDTH-1:0]      rdata_B,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [WIDTH-1:0]      dbg_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // Entry 0 exists so that every address indexes the array directly.
  // It is cleared by reset and is never loaded.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_wsel;

  // Shared read-port logic.
  // - Address 0 and active reset both force zero.
  // - The optional bypass forwards the pending write data.
  // - An X on we evaluates as false, so the stored value is returned.
  function automatic logic [WIDTH-1:0] read_sel(
    input logic [DEPTH_LOG2-1:0] a,
    input logic [WIDTH-1:0]      stored,
    input logic                  rst_i,
    input logic                  we_i,
    input logic [DEPTH_LOG2-1:0] waddr_i,
    input logic [WIDTH-1:0]      wdata_i
  );
    logic [WIDTH-1:0] v;
    if (rst_i || (a == {DEPTH_LOG2{1'b0}})) begin
      v = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && we_i && (waddr_i == a)) begin
      v = wdata_i;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // One-hot write decode. An X on we selects nothing, so an unknown enable
  // can only ever leave registers untouched.
  always_comb begin
    w_wsel = {DEPTH{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      if (we && (waddr == DEPTH_LOG2'(i))) begin
        w_wsel[i] = 1'b1;
      end else begin
        w_wsel[i] = 1'b0;
      end
    end
  end

  // Register storage: asynchronous clear; per-entry load on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wsel[i]) begin
          r_mem[i] <= wdata;
        end else begin
          r_mem[i] <= r_mem[i];
        end
      end
    end
  end

  // Zero-latency combinational read ports.
  always_comb begin
    rdata_A  = read_sel(raddr_A,  r_mem[raddr_A],  rst, we, waddr, wdata);
    rdata_B  = read_sel(raddr_B,  r_mem[raddr_B],  rst, we, waddr, wdata);
    dbg_data = read_sel(dbg_addr, r_mem[dbg_addr], rst, we, waddr, wdata);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file.
// Stimulus pushes expected port values into a queue and raises an event.
// A separate monitor pops each entry and compares it with the DUT output.
// Two instances share all inputs:
//   - dut   with BYPASS=0
//   - dut_b with BYPASS=1
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  raddr_A, raddr_B, waddr, dbg_addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata_A, rdata_B, dbg_data;
  logic [31:0] rdata_A_b, rdata_B_b, dbg_data_b;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb[$];
  event sample_ev;
  int   tests_run = 0;
  int   tests_failed = 0;

  reg_file #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(0)) dut (
    .clk(clk), .rst(rst), .raddr_A(raddr_A), .raddr_B(raddr_B),
    .waddr(waddr), .wdata(wdata), .we(we),
    .rdata_A(rdata_A), .rdata_B(rdata_B),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_file #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .raddr_A(raddr_A), .raddr_B(raddr_B),
    .waddr(waddr), .wdata(wdata), .we(we),
    .rdata_A(rdata_A_b), .rdata_B(rdata_B_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port codes:
  //   0..2 = dut   A / B / dbg
  //   3..5 = dut_b A / B / dbg
  //   6    = ALU subtract (op 3'b100) of dut A - B
  function automatic logic [31:0] port_val(input int p);
    case (p)
      0:       return rdata_A;
      1:       return rdata_B;
      2:       return dbg_data;
      3:       return rdata_A_b;
      4:       return rdata_B_b;
      5:       return dbg_data_b;
      6:       return rdata_A - rdata_B;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: drains the scoreboard every time stimulus presents a sample point.
  initial begin
    sb_t e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = port_val(e.port);
        tests_run++;
        if (act !== e.exp) begin
          tests_failed++;
          $display("FAIL %s (port %0d): got %h, expected %h",
                   e.name, e.port, act, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input int port, input logic [31:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Let the combinational outputs settle, hand the sample point to the
  // monitor, then step off it.
  task automatic fire();
    #1;
    -> sample_ev;
    #1;
  endtask

  // Starting at a negedge, write one register across the next rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    waddr = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] v;

    rst      = 1'b1;
    we       = 1'b0;
    waddr    = 5'd0;
    wdata    = 32'h0;
    raddr_A  = 5'd5;
    raddr_B  = 5'd3;
    dbg_addr = 5'd31;

    // Reset state.
    expect_v(0, 32'h0, "reset_A");
    expect_v(1, 32'h0, "reset_B");
    expect_v(2, 32'h0, "reset_dbg");
    expect_v(3, 32'h0, "reset_A_byp");
    fire();
    @(negedge clk);
    rst = 1'b0;

    // Reset pulse between clock edges clears r5 immediately.
    wr(5'd5, 32'h1234_5678);
    raddr_A  = 5'd5;
    dbg_addr = 5'd5;
    expect_v(0, 32'h1234_5678, "r5_loaded");
    fire();
    rst = 1'b1;
    expect_v(0, 32'h0, "async_rst_A");
    expect_v(2, 32'h0, "async_rst_dbg");
    fire();
    rst = 1'b0;
    @(negedge clk);
    expect_v(0, 32'h0, "r5_after_pulse");
    fire();

    // A write to r0 is discarded.
    wr(5'd0, 32'hFFFF_FFFF);
    raddr_A  = 5'd0;
    dbg_addr = 5'd0;
    expect_v(0, 32'h0, "r0_A");
    expect_v(3, 32'h0, "r0_A_byp");
    expect_v(2, 32'h0, "r0_dbg");
    fire();

    // Basic write/read, then feed the ALU subtract (5 - 3 = 2).
    @(negedge clk);
    wr(5'd1, 32'h0000_0005);
    wr(5'd2, 32'h0000_0003);
    raddr_A = 5'd1;
    raddr_B = 5'd2;
    expect_v(0, 32'h5, "basic_A");
    expect_v(1, 32'h3, "basic_B");
    expect_v(6, 32'h2, "alu_sub");
    expect_v(3, 32'h5, "basic_A_byp");
    expect_v(4, 32'h3, "basic_B_byp");
    fire();

    // Write-enable gating: we=0 held across three edges.
    @(negedge clk);
    we    = 1'b0;
    waddr = 5'd1;
    wdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    expect_v(0, 32'h5, "we_gate_A");
    expect_v(3, 32'h5, "we_gate_A_byp");
    fire();

    // Same-cycle read/write hazard on r7.
    @(negedge clk);
    wr(5'd7, 32'hA);
    raddr_A  = 5'd7;
    dbg_addr = 5'd7;
    waddr    = 5'd7;
    wdata    = 32'hB;
    we       = 1'b1;
    expect_v(0, 32'hA, "hazard_pre_A");
    expect_v(2, 32'hA, "hazard_pre_dbg");
    expect_v(3, 32'hB, "hazard_pre_A_byp");
    expect_v(5, 32'hB, "hazard_pre_dbg_byp");
    fire();
    @(posedge clk);
    expect_v(0, 32'hB, "hazard_post_A");
    expect_v(3, 32'hB, "hazard_post_A_byp");
    fire();
    @(negedge clk);
    we = 1'b0;

    // Full sweep: write every register, then read it on all three ports.
    for (int n = 1; n < 32; n++) begin
      v = 32'(n) * 32'h0101_0101;
      wr(5'(n), v);
    end
    for (int n = 0; n < 32; n++) begin
      v = (n == 0) ? 32'h0 : 32'(n) * 32'h0101_0101;
      raddr_A  = 5'(n);
      raddr_B  = 5'(n);
      dbg_addr = 5'(n);
      expect_v(0, v, "sweep_A");
      expect_v(1, v, "sweep_B");
      expect_v(2, v, "sweep_dbg");
      expect_v(3, v, "sweep_A_byp");
      expect_v(4, v, "sweep_B_byp");
      expect_v(5, v, "sweep_dbg_byp");
      fire();
      @(negedge clk);
    end

    // Reset asserted in the same cycle as a write to r9.
    we       = 1'b1;
    waddr    = 5'd9;
    wdata    = 32'h55;
    raddr_A  = 5'd9;
    raddr_B  = 5'd1;
    dbg_addr = 5'd9;
    rst      = 1'b1;
    expect_v(0, 32'h0, "rstw_A");
    expect_v(1, 32'h0, "rstw_B");
    expect_v(3, 32'h0, "rstw_A_byp");
    expect_v(5, 32'h0, "rstw_dbg_byp");
    fire();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst      = 1'b0;
    we       = 1'b0;
    dbg_addr = 5'd31;
    expect_v(0, 32'h0, "rstw_r9_after");
    expect_v(1, 32'h0, "rstw_r1_after");
    expect_v(2, 32'h0, "rstw_r31_after");
    expect_v(3, 32'h0, "rstw_r9_after_byp");
    fire();
    @(negedge clk);
    wr(5'd9, 32'h55);
    expect_v(0, 32'h55, "r9_legal_write");
    fire();

    @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU:
  - rdata_A drives ALU operand A.
  - rdata_B drives the ALU B-operand mux, which selects between register and immediate.
- The write port takes the ALU Result or memory data from the writeback mux.
- Adds a third read-only debug port for the board display logic.

Parameters:
- WIDTH, 32: register width in bits; must equal the ALU operand width.
- DEPTH_LOG2, 5: address width; the file holds 2**DEPTH_LOG2 registers.
- BYPASS, 0: 1 = a write in flight this cycle is forwarded to the read ports; 0 = reads return stored contents only.

Ports:
- clk  in  1  system clock; all writes occur on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr_A  in  DEPTH_LOG2  read port A address (rs field).
- raddr_B  in  DEPTH_LOG2  read port B address (rt field).
- waddr  in  DEPTH_LOG2  write address (rd/rt, chosen by RegDst).
- wdata  in  WIDTH  write data from the writeback mux.
- we  in  1  write enable (RegWrite).
- rdata_A  out  WIDTH  read port A data (to ALU A).
- rdata_B  out  WIDTH  read port B data (to ALU B mux and store data).
- dbg_addr  in  DEPTH_LOG2  debug read address.
- dbg_data  out  WIDTH  debug read data.

Behaviour:
- Storage: DEPTH registers r0..r(DEPTH-1). r0 is hardwired to zero.
  - Writes with waddr==0 are discarded.
  - Reads of address 0 return 0 on all ports, regardless of BYPASS.
- Reset:
  - rst high clears every register to 0 immediately, without waiting for clk.
  - While rst is high, all read ports return 0 and writes are ignored.
  - Reset deassertion needs no synchronizer inside this block; the first write can occur on the first rising edge after rst falls.
- Write:
  - On the rising clk edge with we=1, rst=0 and waddr!=0, mem[waddr] <= wdata.
  - The new value is visible on the read ports immediately after that edge, so write-to-read latency is 1 edge.
  - we=0 leaves all registers unchanged.
- Read:
  - All three ports are purely combinational with zero latency: rdata_X = mem[raddr_X].
  - Reads of the same address on multiple ports are independent, with no arbitration.
- Same-cycle read/write to the same address (raddr==waddr, we=1, waddr!=0):
  - BYPASS=0: the port returns the old stored value until the edge, then the new value.
  - BYPASS=1: the port returns wdata combinationally in that same cycle. This applies to rdata_A, rdata_B and dbg_data alike.
- Width rules:
  - No sign or zero extension is applied; data passes through unmodified.
  - Addresses are fully decoded; with the default DEPTH_LOG2 there are no out-of-range addresses.
- X-handling:
  - An X or Z on we must not corrupt registers other than the addressed one.
  - The bench treats X on we as an error, not defined behaviour.

Test Plan:
- Reset and r0:
  - Stimulus: pulse rst mid-cycle (not aligned to clk) after loading r5=32'h1234_5678.
  - Required: rdata_A (raddr_A=5) goes to 0 during the pulse, before any clk edge.
  - Then write we=1, waddr=0, wdata=32'hFFFF_FFFF. Required: rdata_A with raddr_A=0 stays 32'h0.
- Basic write/read:
  - Stimulus: write r1=32'h0000_0005 and r2=32'h0000_0003 on consecutive edges, then set raddr_A=1, raddr_B=2.
  - Required: rdata_A=5 and rdata_B=3 in the same cycle. Fed to the ALU with op 3'b100, Result=2.
- Write enable gating:
  - Stimulus: we=0, waddr=1, wdata=32'hDEAD_BEEF for 3 edges.
  - Required: r1 still reads 32'h0000_0005.
- Same-cycle hazard:
  - Stimulus: r7 holds 32'hA, then we=1, waddr=7, wdata=32'hB with raddr_A=7 before the edge.
  - BYPASS=0: rdata_A=32'hA before the edge and 32'hB after.
  - BYPASS=1: rdata_A=32'hB before the edge.
- Full sweep:
  - Stimulus: write rN = N*32'h0101_0101 for N=1..31, then read each via all three ports.
  - Required: every port returns the written value, and r0 returns 0.
- Reset mid-write:
  - Stimulus: assert rst in the same cycle as we=1, waddr=9, wdata=32'h55.
  - Required: after the edge r9=0, and all registers read 0 until the next legal write.
